// File: rtl/fs_accel_out_pack.sv
// Post-quantization output stage: zero-point add, clamp to int8, pack four
// bytes per word and buffer packed words in a show-ahead FIFO.
module fs_accel_out_pack #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SAT_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          out_offset,
    input  logic [7:0]           act_min,
    input  logic [7:0]           act_max,
    input  logic                 flush,
    input  logic                 clr,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    // stage-1 registers
    logic        s1_valid;
    logic        s1_flush;
    logic [7:0]  s1_byte;

    // pack FSM registers
    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;

    // FIFO registers
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // combinational intermediates
    logic               accept_c;
    logic               flush_take_c;
    logic signed [32:0] sum_c;
    logic signed [32:0] min_c;
    logic signed [32:0] max_c;
    logic signed [32:0] lo_c;
    logic signed [32:0] y_c;
    logic               sat_c;
    logic [31:0]        merged_c;
    logic               push_c;
    logic [31:0]        push_word_c;
    logic               pop_c;
    logic [AW-1:0]      rd_ptr_d;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      left_c;
    logic [31:0]        head_d;

    // Beat acceptance; flush is only taken while the stage is ready.
    always_comb begin
        accept_c     = in_valid & in_ready;
        flush_take_c = flush & in_ready;
    end

    // Zero-point add in 33 bits (cannot overflow), then clamp low, then high.
    always_comb begin
        sum_c = $signed({in_data[31], in_data}) + $signed({out_offset[31], out_offset});
        min_c = $signed({{25{act_min[7]}}, act_min});
        max_c = $signed({{25{act_max[7]}}, act_max});
        lo_c  = (sum_c < min_c) ? min_c : sum_c;
        y_c   = (lo_c > max_c) ? max_c : lo_c;
        sat_c = (y_c != sum_c);
    end

    // Stage-1 register and saturation counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_flush <= 1'b0;
            s1_byte  <= 8'h00;
            sat_cnt  <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_flush <= 1'b0;
            s1_byte  <= 8'h00;
            sat_cnt  <= '0;
        end else begin
            s1_valid <= accept_c;
            s1_flush <= flush_take_c;
            if (accept_c) begin
                s1_byte <= y_c[7:0];
            end
            if (accept_c && sat_c && !(&sat_cnt)) begin
                sat_cnt <= sat_cnt + SAT_CNT_W'(1);
            end
        end
    end

    // Pack FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            lane_q  <= 2'd0;
            word_q  <= 32'h0;
        end else if (clr) begin
            state_q <= ST_EMPTY;
            lane_q  <= 2'd0;
            word_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
        end
    end

    // Pack FSM next state: place the byte, push on lane 3 or on flush.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        push_c      = 1'b0;
        push_word_c = word_q;
        merged_c    = word_q;
        if (s1_valid) begin
            merged_c[{lane_q, 3'b000} +: 8] = s1_byte;
        end
        case (state_q)
            ST_EMPTY: begin
                if (s1_valid) begin
                    if (s1_flush) begin
                        push_c      = 1'b1;
                        push_word_c = merged_c;
                        word_d      = 32'h0;
                        lane_d      = 2'd0;
                    end else begin
                        word_d  = merged_c;
                        lane_d  = 2'd1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (s1_valid) begin
                    if (lane_q == 2'd3 || s1_flush) begin
                        push_c      = 1'b1;
                        push_word_c = merged_c;
                        word_d      = 32'h0;
                        lane_d      = 2'd0;
                        state_d     = ST_EMPTY;
                    end else begin
                        word_d = merged_c;
                        lane_d = lane_q + 2'd1;
                    end
                end else if (s1_flush) begin
                    push_c      = 1'b1;
                    push_word_c = word_q;
                    word_d      = 32'h0;
                    lane_d      = 2'd0;
                    state_d     = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                lane_d  = 2'd0;
                word_d  = 32'h0;
            end
        endcase
    end

    // FIFO next values, including the registered show-ahead head word.
    always_comb begin
        pop_c    = out_valid & out_ready;
        rd_ptr_d = rd_ptr_q + AW'(pop_c);
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        left_c   = count_q - CW'(pop_c);
        if (left_c != '0) begin
            head_d = mem[rd_ptr_d];
        end else if (push_c) begin
            head_d = push_word_c;
        end else begin
            head_d = 32'h0;
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr_q] <= push_word_c;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_valid <= (count_d != '0);
            out_data  <= head_d;
            in_ready  <= (count_d < CW'(FIFO_DEPTH - 1));
            busy      <= accept_c | flush_take_c | (lane_d != 2'd0) | (count_d != '0);
        end
    end

endmodule

// File: tb/tb_fs_accel_out_pack.sv
// Randomized scoreboard bench for fs_accel_out_pack.
module tb_fs_accel_out_pack;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_offset;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic        flush;
    logic        clr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] sat_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];
    logic [15:0] sat_exp = 16'h0;
    logic        rand_rdy = 1'b0;

    fs_accel_out_pack #(.FIFO_DEPTH(4), .SAT_CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_offset(out_offset), .act_min(act_min),
        .act_max(act_max), .flush(flush), .clr(clr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: int8 result of clamp(data+offset) and word assembly.
    function automatic void model_beat(input logic [31:0] d, input logic fl, input logic v);
        longint s, c, y, mn, mx;
        logic [31:0] w;
        if (v) begin
            s  = longint'($signed(d)) + longint'($signed(out_offset));
            mn = longint'($signed(act_min));
            mx = longint'($signed(act_max));
            c  = (s < mn) ? mn : s;
            y  = (c > mx) ? mx : c;
            byte_q.push_back(8'(y));
            if (y != s && sat_exp != 16'hFFFF) sat_exp++;
        end
        if (byte_q.size() == 4 || (fl && byte_q.size() != 0)) begin
            w = 32'h0;
            for (int i = 0; i < byte_q.size(); i++) w[8*i +: 8] = byte_q[i];
            exp_q.push_back(w);
            byte_q.delete();
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        byte_q.delete();
        sat_exp = 16'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(input logic [31:0] d, input logic fl);
        in_data  = d;
        flush    = fl;
        in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(d, fl, 1'b1);
                tick();
                in_valid = 1'b0;
                flush    = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("beat_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic flush_only();
        flush    = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(32'h0, 1'b1, 1'b0);
                tick();
                flush = 1'b0;
                return;
            end
            tick();
        end
        flush = 1'b0;
        chk("flush_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
        tick();
        tick();
        chk({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        chk({name, "_sat_cnt"}, 32'(sat_cnt), 32'(sat_exp));
    endtask

    task automatic set_cfg(input logic [31:0] off, input logic [7:0] mn, input logic [7:0] mx);
        out_offset = off;
        act_min    = mn;
        act_max    = mx;
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({name, "_out_data"}, out_data, 32'h0);
        chk({name, "_busy"}, 32'(busy), 32'h0);
        chk({name, "_sat_cnt"}, 32'(sat_cnt), 32'h0);
    endtask

    // Fill two words plus a partial one while the consumer stalls.
    task automatic fill_for_clear();
        out_ready = 1'b0;
        set_cfg(32'h0, 8'h80, 8'h7F);
        for (int i = 0; i < 10; i++) beat((i % 3 == 0) ? 32'd1000 : 32'(i), 1'b0);
        repeat (3) tick();
        chk("prefill_out_valid", 32'(out_valid), 32'h1);
        chk("prefill_busy", 32'(busy), 32'h1);
    endtask

    // Monitor: pop and compare on every transfer; check stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    always @(negedge clk) begin
        if (!resetn || clr) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 32'h1);
                chk("stall_hold_data", out_data, prev_data);
            end
            if (!out_valid) begin
                if (out_data !== 32'h0) chk("empty_out_data", out_data, 32'h0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hFFFFFFFF);
                end else begin
                    chk("word", out_data, exp_q.pop_front());
                end
            end
            prev_stall <= out_valid & ~out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        resetn    = 1'b0;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        set_cfg(32'd5, 8'h80, 8'h7F);
        #3;
        chk_cleared("reset");
        #20;
        resetn = 1'b1;
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'h1);

        // Basic full word.
        out_ready = 1'b1;
        set_cfg(32'd5, 8'h80, 8'h7F);
        beat(32'd10, 1'b0); beat(-32'sd3, 1'b0); beat(32'd0, 1'b0); beat(32'd100, 1'b0);
        drain("t1");

        // Partial word closed by flush-only entry.
        set_cfg(-32'sd128, 8'h80, 8'h7F);
        beat(32'd200, 1'b0); beat(-32'sd50, 1'b0); beat(32'd7, 1'b0);
        flush_only();
        drain("t2");

        // ReLU6 clamp.
        set_cfg(32'd0, 8'h00, 8'h06);
        beat(-32'sd9, 1'b0); beat(32'd3, 1'b0); beat(32'd6, 1'b0); beat(32'd40, 1'b0);
        drain("t3");

        // Extreme input, and two-cycle latency from beat to out_valid.
        out_ready = 1'b0;
        set_cfg(32'd1, 8'h80, 8'h7F);
        beat(32'h7FFFFFFF, 1'b1);
        chk("latency_edge1", 32'(out_valid), 32'h0);
        tick();
        chk("latency_edge2", 32'(out_valid), 32'h1);
        chk("latency_data", out_data, 32'h0000007F);
        out_ready = 1'b1;
        drain("t_max");

        // Inverted bounds give act_max.
        set_cfg(32'd0, 8'd10, 8'd5);
        beat(32'd0, 1'b0); beat(32'd7, 1'b0); beat(-32'sd40, 1'b1);
        drain("t_inv");

        // Flush with the fourth byte: exactly one word.
        set_cfg(32'd0, 8'h80, 8'h7F);
        beat(32'd1, 1'b0); beat(32'd2, 1'b0); beat(32'd3, 1'b0); beat(32'd4, 1'b1);
        flush_only();
        drain("t_flush4");
        chk("t_flush4_idle", 32'(out_valid), 32'h0);

        // Back-pressure: 16 beats with consumer stalled.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) beat(32'(i * 7 - 20), 1'b0);
            end
            begin
                repeat (40) tick();
                chk("bp_in_ready_low", 32'(in_ready), 32'h0);
                chk("bp_words_queued", 32'(exp_q.size()), 32'h3);
                out_ready = 1'b1;
            end
        join
        drain("t_bp");

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0)
                set_cfg(32'($urandom_range(0, 300)) - 32'd150, 8'($urandom), 8'($urandom));
            case ($urandom_range(0, 3))
                0:       in_data = $urandom;
                default: in_data = 32'($urandom_range(0, 400)) - 32'd200;
            endcase
            if ($urandom_range(0, 15) == 0) flush_only();
            else beat(in_data, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        flush_only();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain("t_rand");

        // Asynchronous reset mid-word with two words queued.
        fill_for_clear();
        #2;
        resetn = 1'b0;
        #1;
        chk_cleared("arst");
        model_clear();
        #10;
        resetn = 1'b1;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        beat(32'd11, 1'b0); beat(32'd22, 1'b0); beat(32'd33, 1'b0); beat(32'd44, 1'b0);
        drain("t_arst");

        // Soft clear mid-word; the beat in the clear cycle is dropped.
        fill_for_clear();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd123;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk_cleared("clr");
        chk("clr_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        beat(32'd11, 1'b0); beat(32'd22, 1'b0); beat(32'd33, 1'b0); beat(32'd44, 1'b0);
        drain("t_clr");
        chk("final_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
